// File: rtl/cp0_exc_seq_if.sv
// Interface between the MEM-stage exception sequencer, the pipeline and the CP0 register file.
// slave = sequencer side, master = pipeline/CP0 side.
interface cp0_exc_seq_if;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_ds_i;
    logic [4:0]  mem_exc_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        pipe_we_i;
    logic [4:0]  pipe_waddr_i;
    logic [31:0] pipe_wdata_i;
    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_wdata_o;
    logic        stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [4:0]  exc_code_o;
    logic        busy_o;

    modport slave (
        input  mem_valid_i, mem_pc_i, mem_in_ds_i, mem_exc_i,
        input  status_i, cause_i, epc_i,
        input  pipe_we_i, pipe_waddr_i, pipe_wdata_i,
        output cp0_we_o, cp0_waddr_o, cp0_wdata_o,
        output stall_o, flush_o, new_pc_o, exc_code_o, busy_o
    );

    modport master (
        output mem_valid_i, mem_pc_i, mem_in_ds_i, mem_exc_i,
        output status_i, cause_i, epc_i,
        output pipe_we_i, pipe_waddr_i, pipe_wdata_i,
        input  cp0_we_o, cp0_waddr_o, cp0_wdata_o,
        input  stall_o, flush_o, new_pc_o, exc_code_o, busy_o
    );
endinterface

// File: rtl/cp0_exc_seq.sv
// CP0 exception/interrupt sequencer: writes EPC, CAUSE, STATUS then flushes to the handler (4 cycles), or STATUS then EPC (eret, 2 cycles).
// Stalls the pipeline from accept through redirect; mtc0 writes pass straight through only while idle.
module cp0_exc_seq #(
    parameter logic [31:0] HANDLER_PC  = 32'h0000_0020,
    parameter logic [4:0]  ADDR_STATUS = 5'd12,
    parameter logic [4:0]  ADDR_CAUSE  = 5'd13,
    parameter logic [4:0]  ADDR_EPC    = 5'd14
) (
    input  logic          clk,
    input  logic          rst,
    cp0_exc_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_STATUS,
        REDIRECT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_val_q, epc_val_d;
    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [25:0] cause_q, cause_d;    // {cause[30:7], cause[1:0]}; BD and ExcCode are rebuilt
    logic [4:0]  code_q, code_d;
    logic        bd_q, bd_d;
    logic        eret_q, eret_d;

    logic        int_p, exc_hit, accept, sel_eret;
    logic [4:0]  sel_code;

    logic        we_c, stall_c, flush_c;
    logic [4:0]  waddr_c;
    logic [31:0] wdata_c, new_pc_c;

    // Event decode; the interrupt outranks every instruction flag, eret is last.
    always_comb begin
        int_p    = bus.status_i[0] & ~bus.status_i[1]
                 & (|(bus.cause_i[15:8] & bus.status_i[15:8]));
        exc_hit  = bus.mem_valid_i & (|bus.mem_exc_i);
        accept   = (state_q == IDLE) & (int_p | exc_hit);
        sel_eret = 1'b0;
        sel_code = 5'h00;
        if (int_p)                 sel_code = 5'h00;
        else if (bus.mem_exc_i[1]) sel_code = 5'h0A;
        else if (bus.mem_exc_i[2]) sel_code = 5'h0C;
        else if (bus.mem_exc_i[3]) sel_code = 5'h0D;
        else if (bus.mem_exc_i[0]) sel_code = 5'h08;
        else                       sel_eret = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        epc_val_d = epc_val_q;
        status_d  = status_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        code_d    = code_q;
        bd_d      = bd_q;
        eret_d    = eret_q;
        we_c      = 1'b0;
        waddr_c   = '0;
        wdata_c   = '0;
        stall_c   = 1'b0;
        flush_c   = 1'b0;
        new_pc_c  = '0;
        unique case (state_q)
            IDLE: begin
                we_c    = bus.pipe_we_i;
                waddr_c = bus.pipe_waddr_i;
                wdata_c = bus.pipe_wdata_i;
                if (accept) begin
                    // The pipeline is about to be flushed, so its mtc0 is dropped.
                    we_c      = 1'b0;
                    stall_c   = 1'b1;
                    epc_val_d = bus.mem_in_ds_i ? (bus.mem_pc_i - 32'd4) : bus.mem_pc_i;
                    bd_d      = bus.mem_in_ds_i;
                    status_d  = bus.status_i;
                    cause_d   = {bus.cause_i[30:7], bus.cause_i[1:0]};
                    epc_d     = bus.epc_i;
                    eret_d    = sel_eret;
                    if (!sel_eret) code_d = sel_code;
                    state_d   = sel_eret ? W_STATUS : W_EPC;
                end
            end
            W_EPC: begin
                we_c    = 1'b1;
                waddr_c = ADDR_EPC;
                wdata_c = epc_val_q;
                stall_c = 1'b1;
                state_d = W_CAUSE;
            end
            W_CAUSE: begin
                we_c    = 1'b1;
                waddr_c = ADDR_CAUSE;
                wdata_c = {bd_q, cause_q[25:2], code_q, cause_q[1:0]};
                stall_c = 1'b1;
                state_d = W_STATUS;
            end
            W_STATUS: begin
                we_c    = 1'b1;
                waddr_c = ADDR_STATUS;
                wdata_c = eret_q ? (status_q & ~32'h2) : (status_q | 32'h2);
                stall_c = 1'b1;
                state_d = REDIRECT;
            end
            REDIRECT: begin
                stall_c  = 1'b1;
                flush_c  = 1'b1;
                new_pc_c = eret_q ? epc_q : HANDLER_PC;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            epc_val_q <= '0;
            status_q  <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
            code_q    <= '0;
            bd_q      <= 1'b0;
            eret_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            epc_val_q <= epc_val_d;
            status_q  <= status_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            code_q    <= code_d;
            bd_q      <= bd_d;
            eret_q    <= eret_d;
        end
    end

    assign bus.cp0_we_o    = we_c;
    assign bus.cp0_waddr_o = waddr_c;
    assign bus.cp0_wdata_o = wdata_c;
    assign bus.stall_o     = stall_c;
    assign bus.flush_o     = flush_c;
    assign bus.new_pc_o    = new_pc_c;
    assign bus.exc_code_o  = code_q;
    assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Bench for cp0_exc_seq: directed scenarios plus randomized events against a write-list reference model.
module tb_cp0_exc_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cp0_exc_seq_if bus ();

    cp0_exc_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        stall;
        logic        flush;
        logic [31:0] npc;
        logic        busy;
        logic [4:0]  code;
    } obs_t;

    obs_t obs [8];

    function automatic obs_t sample();
        obs_t o;
        o.we    = bus.cp0_we_o;
        o.addr  = bus.cp0_waddr_o;
        o.data  = bus.cp0_wdata_o;
        o.stall = bus.stall_o;
        o.flush = bus.flush_o;
        o.npc   = bus.new_pc_o;
        o.busy  = bus.busy_o;
        o.code  = bus.exc_code_o;
        return o;
    endfunction

    task automatic set_quiet();
        bus.mem_valid_i  = 1'b0;
        bus.mem_pc_i     = '0;
        bus.mem_in_ds_i  = 1'b0;
        bus.mem_exc_i    = '0;
        bus.status_i     = '0;
        bus.cause_i      = '0;
        bus.epc_i        = '0;
        bus.pipe_we_i    = 1'b0;
        bus.pipe_waddr_i = '0;
        bus.pipe_wdata_i = '0;
    endtask

    task automatic drive_random();
        bus.mem_valid_i  = 1'($urandom);
        bus.mem_pc_i     = $urandom;
        bus.mem_in_ds_i  = 1'($urandom);
        bus.mem_exc_i    = 5'($urandom);
        bus.status_i     = $urandom;
        bus.cause_i      = $urandom;
        bus.epc_i        = $urandom;
        bus.pipe_we_i    = 1'($urandom);
        bus.pipe_waddr_i = 5'($urandom);
        bus.pipe_wdata_i = $urandom;
    endtask

    // Called in the slot just after a rising edge with the accept-cycle inputs applied.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                if (i == 1) set_quiet();
            end
            @(negedge clk);
            obs[i] = sample();
        end
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b0;
        set_quiet();
        bus.pipe_we_i    = 1'b1;
        bus.pipe_waddr_i = 5'd9;
        bus.pipe_wdata_i = 32'hDEAD_BEEF;
        #3;
        o = sample();
        checks++;
        if ({o.stall, o.flush, o.busy, o.npc, o.code} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b flush=%b busy=%b npc=%h code=%h want all 0",
                     o.stall, o.flush, o.busy, o.npc, o.code);
        end
        checks++;
        if ({o.we, o.addr, o.data} !== {1'b1, 5'd9, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL reset_passthru got we=%b addr=%0d data=%h want 1/9/deadbeef",
                     o.we, o.addr, o.data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        set_quiet();
    endtask

    task automatic test_syscall();
        int nstall;
        @(posedge clk); #1;
        set_quiet();
        bus.mem_valid_i = 1'b1;
        bus.mem_exc_i   = 5'b00001;
        bus.mem_pc_i    = 32'h100;
        bus.status_i    = 32'h1000_0001;
        capture(6);
        checks++;
        if ({obs[0].we, obs[0].stall, obs[0].busy} !== 3'b010) begin
            errors++;
            $display("FAIL sys_accept got we=%b stall=%b busy=%b want 0/1/0", obs[0].we, obs[0].stall, obs[0].busy);
        end
        checks++;
        if ({obs[1].we, obs[1].addr, obs[1].data} !== {1'b1, 5'd14, 32'h100}) begin
            errors++;
            $display("FAIL sys_epc got we=%b addr=%0d data=%h want 1/14/100", obs[1].we, obs[1].addr, obs[1].data);
        end
        checks++;
        if ({obs[2].we, obs[2].addr, obs[2].data[31], obs[2].data[6:2]} !== {1'b1, 5'd13, 1'b0, 5'h08}) begin
            errors++;
            $display("FAIL sys_cause got we=%b addr=%0d data=%h want 1/13 bd=0 code=08", obs[2].we, obs[2].addr, obs[2].data);
        end
        checks++;
        if ({obs[3].we, obs[3].addr, obs[3].data} !== {1'b1, 5'd12, 32'h1000_0003}) begin
            errors++;
            $display("FAIL sys_status got we=%b addr=%0d data=%h want 1/12/10000003", obs[3].we, obs[3].addr, obs[3].data);
        end
        checks++;
        if ({obs[4].we, obs[4].flush, obs[4].npc} !== {1'b0, 1'b1, 32'h20}) begin
            errors++;
            $display("FAIL sys_redirect got we=%b flush=%b npc=%h want 0/1/20", obs[4].we, obs[4].flush, obs[4].npc);
        end
        nstall = 0;
        for (int i = 0; i < 6; i++) nstall += int'(obs[i].stall);
        checks++;
        if (nstall != 5 || obs[5].stall !== 1'b0 || obs[5].busy !== 1'b0) begin
            errors++;
            $display("FAIL sys_stall_len got %0d cycles (last stall=%b busy=%b) want 5", nstall, obs[5].stall, obs[5].busy);
        end
        checks++;
        if (obs[5].code !== 5'h08) begin
            errors++;
            $display("FAIL sys_code got %h want 08", obs[5].code);
        end
    endtask

    task automatic test_ds_overflow();
        @(posedge clk); #1;
        set_quiet();
        bus.mem_valid_i = 1'b1;
        bus.mem_exc_i   = 5'b00100;
        bus.mem_pc_i    = 32'h204;
        bus.mem_in_ds_i = 1'b1;
        bus.status_i    = 32'h1000_0001;
        capture(5);
        checks++;
        if ({obs[1].addr, obs[1].data} !== {5'd14, 32'h200}) begin
            errors++;
            $display("FAIL ds_epc got addr=%0d data=%h want 14/200", obs[1].addr, obs[1].data);
        end
        checks++;
        if ({obs[2].addr, obs[2].data} !== {5'd13, 32'h8000_0030}) begin
            errors++;
            $display("FAIL ds_cause got addr=%0d data=%h want 13/80000030", obs[2].addr, obs[2].data);
        end
    endtask

    task automatic test_eret();
        int bad;
        @(posedge clk); #1;
        set_quiet();
        bus.mem_valid_i = 1'b1;
        bus.mem_exc_i   = 5'b10000;
        bus.status_i    = 32'h1000_0003;
        bus.epc_i       = 32'h104;
        capture(4);
        checks++;
        if ({obs[1].we, obs[1].addr, obs[1].data} !== {1'b1, 5'd12, 32'h1000_0001}) begin
            errors++;
            $display("FAIL eret_status got we=%b addr=%0d data=%h want 1/12/10000001", obs[1].we, obs[1].addr, obs[1].data);
        end
        checks++;
        if ({obs[2].flush, obs[2].npc, obs[1].flush, obs[3].flush} !== {1'b1, 32'h104, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL eret_redirect got flush@2=%b npc=%h flush@1=%b flush@3=%b want 1/104/0/0",
                     obs[2].flush, obs[2].npc, obs[1].flush, obs[3].flush);
        end
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (obs[i].we && (obs[i].addr == 5'd13 || obs[i].addr == 5'd14)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL eret_no_epc_cause got %0d writes to 13/14 want 0", bad);
        end
    endtask

    task automatic test_int_mask();
        obs_t o;
        @(posedge clk); #1;
        set_quiet();
        bus.status_i = 32'h0000_8001;
        bus.cause_i  = 32'h0000_8000;
        bus.mem_pc_i = 32'h300;
        capture(6);
        checks++;
        if ({obs[0].stall, obs[1].addr, obs[1].data, obs[2].data} !== {1'b1, 5'd14, 32'h300, 32'h0000_8000}) begin
            errors++;
            $display("FAIL int_accept got stall=%b epc_addr=%0d epc=%h cause=%h want 1/14/300/00008000",
                     obs[0].stall, obs[1].addr, obs[1].data, obs[2].data);
        end
        checks++;
        if (obs[5].code !== 5'h00) begin
            errors++;
            $display("FAIL int_code got %h want 00", obs[5].code);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            set_quiet();
            bus.status_i     = (k == 0) ? 32'h0000_8003 : 32'h0000_0001;
            bus.cause_i      = 32'h0000_8000;
            bus.pipe_we_i    = 1'b1;
            bus.pipe_waddr_i = 5'd12;
            bus.pipe_wdata_i = 32'h0000_ABCD + k;
            @(negedge clk);
            o = sample();
            @(posedge clk); #1;
            set_quiet();
            @(negedge clk);
            checks++;
            if ({o.we, o.addr, o.data, o.stall, bus.busy_o} !== {1'b1, 5'd12, 32'h0000_ABCD + k, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL int_masked%0d got we=%b addr=%0d data=%h stall=%b busy=%b want passthru, no accept",
                         k, o.we, o.addr, o.data, o.stall, bus.busy_o);
            end
        end
    endtask

    task automatic test_simultaneous();
        @(posedge clk); #1;
        set_quiet();
        bus.status_i     = 32'h0000_8001;
        bus.cause_i      = 32'h0000_8000;
        bus.mem_valid_i  = 1'b1;
        bus.mem_exc_i    = 5'b00001;
        bus.mem_pc_i     = 32'h400;
        bus.pipe_we_i    = 1'b1;
        bus.pipe_waddr_i = 5'd12;
        bus.pipe_wdata_i = 32'h5555_5555;
        capture(6);
        checks++;
        if ({obs[0].we, obs[0].stall} !== 2'b01) begin
            errors++;
            $display("FAIL sim_drop_mtc0 got we=%b stall=%b want 0/1", obs[0].we, obs[0].stall);
        end
        checks++;
        if ({obs[1].data, obs[2].data[6:2], obs[5].code} !== {32'h400, 5'h00, 5'h00}) begin
            errors++;
            $display("FAIL sim_int_wins got epc=%h cause_code=%h code=%h want 400/00/00",
                     obs[1].data, obs[2].data[6:2], obs[5].code);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   nwr;
        @(posedge clk); #1;
        set_quiet();
        bus.mem_valid_i = 1'b1;
        bus.mem_exc_i   = 5'b00001;
        bus.mem_pc_i    = 32'h500;
        bus.status_i    = 32'h1000_0001;
        @(negedge clk);
        @(posedge clk); #1;
        set_quiet();
        @(negedge clk);
        o = sample();
        checks++;
        if ({o.we, o.addr, o.data} !== {1'b1, 5'd14, 32'h500}) begin
            errors++;
            $display("FAIL rstmid_epc got we=%b addr=%0d data=%h want 1/14/500", o.we, o.addr, o.data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        o = sample();
        checks++;
        if ({o.we, o.addr} !== {1'b1, 5'd13}) begin
            errors++;
            $display("FAIL rstmid_in_cause got we=%b addr=%0d want 1/13", o.we, o.addr);
        end
        #2 rst = 1'b0;
        #1 o = sample();
        checks++;
        if ({o.busy, o.stall, o.flush, o.we, o.code} !== 9'd0) begin
            errors++;
            $display("FAIL rstmid_idle got busy=%b stall=%b flush=%b we=%b code=%h want all 0",
                     o.busy, o.stall, o.flush, o.we, o.code);
        end
        @(negedge clk);
        rst = 1'b1;
        nwr = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.cp0_we_o || bus.busy_o || bus.flush_o) nwr++;
        end
        checks++;
        if (nwr != 0) begin
            errors++;
            $display("FAIL rstmid_no_status got %0d active cycles after reset want 0", nwr);
        end
    endtask

    task automatic test_random();
        logic [4:0] pats [6];
        pats = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10};
        for (int it = 0; it < 120; it++) begin
            logic [31:0] st, ca, pc, ep, pd, npc;
            logic [4:0]  ex, pa, code;
            logic        mv, ds, pwe, ip, hit, eret;
            logic [4:0]  wa [$];
            logic [31:0] wd [$];
            int          sel;
            obs_t        o;
            wa.delete();
            wd.delete();
            st = $urandom;
            if ($urandom_range(0, 1) == 1) st[1] = 1'b0;
            ca  = $urandom;
            if ($urandom_range(0, 2) == 0) ca[15:8] = 8'h00;
            pc  = $urandom;
            ep  = $urandom;
            pd  = $urandom;
            pa  = 5'($urandom);
            pwe = 1'($urandom);
            mv  = ($urandom_range(0, 3) != 0);
            ds  = 1'($urandom);
            sel = $urandom_range(0, 6);
            ex  = (sel == 6) ? 5'($urandom) : pats[sel];
            @(posedge clk); #1;
            bus.mem_valid_i = mv;  bus.mem_pc_i = pc;  bus.mem_in_ds_i = ds; bus.mem_exc_i = ex;
            bus.status_i = st;     bus.cause_i = ca;   bus.epc_i = ep;
            bus.pipe_we_i = pwe;   bus.pipe_waddr_i = pa; bus.pipe_wdata_i = pd;
            ip   = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h00);
            hit  = mv && (ex != 5'h00);
            eret = !ip && hit && (ex[3:0] == 4'h0);
            @(negedge clk);
            o = sample();
            checks++;
            if (!ip && !hit) begin
                if ({o.we, o.addr, o.data, o.stall, o.flush, o.busy} !== {pwe, pa, pd, 3'b000}) begin
                    errors++;
                    $display("FAIL rnd_passthru it=%0d got we=%b addr=%0d data=%h stall=%b want %b/%0d/%h/0",
                             it, o.we, o.addr, o.data, o.stall, pwe, pa, pd);
                end
            end else begin
                if ({o.we, o.stall, o.flush, o.busy} !== 4'b0100) begin
                    errors++;
                    $display("FAIL rnd_accept it=%0d got we=%b stall=%b flush=%b busy=%b want 0/1/0/0",
                             it, o.we, o.stall, o.flush, o.busy);
                end
                if (ip)          code = 5'h00;
                else if (ex[1])  code = 5'h0A;
                else if (ex[2])  code = 5'h0C;
                else if (ex[3])  code = 5'h0D;
                else             code = 5'h08;
                if (eret) begin
                    wa.push_back(5'd12); wd.push_back(st & ~32'h2);
                    npc = ep;
                end else begin
                    wa.push_back(5'd14); wd.push_back(ds ? pc - 32'd4 : pc);
                    wa.push_back(5'd13); wd.push_back({ds, ca[30:7], code, ca[1:0]});
                    wa.push_back(5'd12); wd.push_back(st | 32'h2);
                    npc = 32'h20;
                end
                foreach (wa[j]) begin
                    @(posedge clk); #1;
                    drive_random();
                    @(negedge clk);
                    o = sample();
                    checks++;
                    if ({o.we, o.addr, o.data, o.stall, o.flush, o.busy} !== {1'b1, wa[j], wd[j], 3'b101}) begin
                        errors++;
                        $display("FAIL rnd_write it=%0d step=%0d got we=%b addr=%0d data=%h stall=%b flush=%b want 1/%0d/%h/1/0",
                                 it, j, o.we, o.addr, o.data, o.stall, o.flush, wa[j], wd[j]);
                    end
                end
                @(posedge clk); #1;
                drive_random();
                @(negedge clk);
                o = sample();
                checks++;
                if ({o.we, o.stall, o.flush, o.busy, o.npc} !== {4'b0111, npc}) begin
                    errors++;
                    $display("FAIL rnd_redirect it=%0d got we=%b stall=%b flush=%b npc=%h want 0/1/1/%h",
                             it, o.we, o.stall, o.flush, o.npc, npc);
                end
                if (!eret) begin
                    checks++;
                    if (o.code !== code) begin
                        errors++;
                        $display("FAIL rnd_code it=%0d got %h want %h", it, o.code, code);
                    end
                end
            end
        end
        @(posedge clk); #1;
        set_quiet();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_syscall();
        test_ds_overflow();
        test_eret();
        test_int_mask();
        test_simultaneous();
        test_reset_mid();
        test_random();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_exc_seq.md
Name: cp0_exc_seq

Overview:
- Exception/interrupt sequencer for the CP0 register file.
- Sits beside the MEM stage and watches each retiring instruction's exception flags, plus pending, enabled interrupts derived from CP0 STATUS/CAUSE.
- On an accepted event it stalls the pipeline and owns CP0's single write port. It writes EPC, CAUSE and STATUS in sequence, then flushes and redirects fetch.
- Outside a sequence, it passes the pipeline's mtc0 writes straight to the CP0 write port.

Parameters:
- HANDLER_PC, 32'h0000_0020, exception vector driven on new_pc_o.
- ADDR_STATUS, 5'd12, CP0 STATUS register number.
- ADDR_CAUSE, 5'd13, CP0 CAUSE register number.
- ADDR_EPC, 5'd14, CP0 EPC register number.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_valid_i  in  1  a valid instruction is in MEM this cycle.
- mem_pc_i  in  32  PC of the MEM instruction.
- mem_in_ds_i  in  1  MEM instruction is in a branch delay slot.
- mem_exc_i  in  5  flags: [0] syscall, [1] reserved instr, [2] overflow, [3] trap, [4] eret.
- status_i  in  32  current CP0 STATUS.
- cause_i  in  32  current CP0 CAUSE.
- epc_i  in  32  current CP0 EPC.
- pipe_we_i  in  1  pipeline mtc0 write request.
- pipe_waddr_i  in  5  mtc0 register number.
- pipe_wdata_i  in  32  mtc0 data.
- cp0_we_o  out  1  CP0 write enable.
- cp0_waddr_o  out  5  CP0 write address.
- cp0_wdata_o  out  32  CP0 write data.
- stall_o  out  1  freeze IF..MEM.
- flush_o  out  1  one-cycle pipeline flush.
- new_pc_o  out  32  redirect target; valid only while flush_o=1.
- exc_code_o  out  5  ExcCode of the last accepted event, held until the next one.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE; latched pc/status/epc/code/bd registers =0. All outputs =0, except that cp0_* mirror pipe_* pass-through as in IDLE.
- Interrupt pending: int_p = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
- Accept condition (IDLE only): int_p, or mem_valid_i & |mem_exc_i.
- Priority when several are set, highest first:
  - interrupt: code 0x00
  - reserved instr: 0x0A
  - overflow: 0x0C
  - trap: 0x0D
  - syscall: 0x08
  - eret (no code)
- Interrupt with mem_valid_i=0: EPC source is mem_pc_i anyway; the pipeline guarantees a valid PC.
- Accept cycle (still IDLE):
  - stall_o=1 combinationally.
  - pipe_we_i is suppressed (cp0_we_o=0) and that write is dropped.
  - Latch: epc_val = mem_in_ds_i ? mem_pc_i-4 : mem_pc_i (mod 2^32); bd = mem_in_ds_i; status_i; cause_i; epc_i; code.
- Exception FSM path: IDLE -> W_EPC -> W_CAUSE -> W_STATUS -> REDIRECT -> IDLE.
  - W_EPC: we=1, addr=ADDR_EPC, data=epc_val.
  - W_CAUSE: we=1, addr=ADDR_CAUSE, data={bd, cause[30:7], code, cause[1:0]}. CP0 applies its own write mask.
  - W_STATUS: we=1, addr=ADDR_STATUS, data=status | 32'h2 (EXL set).
  - REDIRECT: flush_o=1, new_pc_o=HANDLER_PC, we=0.
- ERET path: IDLE -> W_STATUS (data=status & ~32'h2) -> REDIRECT (new_pc_o = latched epc) -> IDLE. EPC and CAUSE are not written.
- Latency: exception flush occurs 4 cycles after accept; eret flush occurs 2 cycles after accept.
- stall_o=1 from the accept cycle through REDIRECT inclusive. busy_o=1 in every non-IDLE state.
- pipe_we_i in non-IDLE states is ignored; the pipeline is stalled and later flushed.
- IDLE with no accept: cp0_we_o=pipe_we_i, cp0_waddr_o=pipe_waddr_i, cp0_wdata_o=pipe_wdata_i (combinational), and stall_o=0.
- New events arriving while busy are not sampled. They are re-evaluated in the first IDLE cycle after REDIRECT.
- Interrupt coinciding with eret or any instruction exception: the interrupt wins and EPC is that instruction's PC.
- rst asserted mid-sequence: immediate return to IDLE; any partial CP0 writes already performed stand.

Test Plan:
- Syscall: mem_valid=1, mem_exc=5'b00001, pc=0x100, in_ds=0, status=0x1000_0001. Required: W_EPC writes 0x100 to reg 14; CAUSE[6:2]=0x08, BD=0; STATUS write 0x1000_0003; next cycle flush_o=1, new_pc=0x20; stall high for 5 cycles.
- Delay-slot overflow: pc=0x204, in_ds=1, exc=5'b00100. Required: EPC write 0x200, CAUSE bit31=1, ExcCode 0x0C.
- ERET: exc=5'b10000, status=0x1000_0003, epc_i=0x104. Required: STATUS write 0x1000_0001, then flush_o=1 with new_pc=0x104; exactly 2 cycles after accept; no writes to reg 13/14.
- Interrupt masking: cause[15:8]=0x80 with status=0x0000_8001 accepts with code 0. The same pending bit with status EXL=1 (0x8003), or with IM7=0, produces no accept; mtc0 passes through unchanged.
- Simultaneous: interrupt pending plus syscall on the same cycle, along with pipe_we_i=1 to reg 12. Required: code 0x00; the mtc0 write is dropped (no we in the accept cycle); EPC = syscall PC.
- Reset: assert rst during W_CAUSE. Required: state IDLE immediately; flush_o=0, stall_o=0; EPC write stands, and no STATUS write occurs.
